div_issue_queue: RTL and testbench

DIV_ISSUE_QUEUE -- requirements
Module: div_issue_queue

---
 rtl/div_issue_queue_pkg.sv | 38 +++
 rtl/div_issue_queue_slot.sv | 63 ++++++
 rtl/div_issue_queue.sv | 93 +++++++++
 tb/tb_div_issue_queue.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_issue_queue_pkg.sv
// rtl/div_issue_queue_pkg.sv - shared types for the divider issue queue
// Entry, CDB and issue payload layouts plus the operand wakeup match.
package div_issue_queue_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 6;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] rd_tag;
    logic [XLEN-1:0]  rs1_data;
    logic [TAG_W-1:0] rs1_tag;
    logic             rs1_valid;
    logic [XLEN-1:0]  rs2_data;
    logic [TAG_W-1:0] rs2_tag;
    logic             rs2_valid;
  } div_rs_entry;

  typedef struct packed {
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_result;
    logic             cdb_branch;
  } cdb_bfm;

  typedef struct packed {
    logic [TAG_W-1:0] rd_tag;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
  } common_fifo_data;

  // Only operands still waiting may be woken; a ready operand keeps its data.
  function automatic logic cdb_hit(input logic cdb_valid, input logic [TAG_W-1:0] cdb_tag,
                                   input logic op_valid, input logic [TAG_W-1:0] op_tag);
    return cdb_valid && !op_valid && (cdb_tag == op_tag);
  endfunction

endpackage

// File: rtl/div_issue_queue_slot.sv
// rtl/div_issue_queue_slot.sv - one reservation entry with CDB snoop and capture
// Dispatch-time bypass lets an operand broadcast in the write cycle land as ready.
module div_rs_entry_slot
  import div_issue_queue_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_write,
  input  div_rs_entry i_wdata,
  input  logic        i_pop,
  input  cdb_bfm      i_cdb,
  output div_rs_entry o_entry
);

  div_rs_entry r_entry;
  logic        w_hit1;
  logic        w_hit2;
  logic        w_wr_hit1;
  logic        w_wr_hit2;
  logic        w_unused_ok;

  assign w_hit1    = cdb_hit(i_cdb.cdb_valid, i_cdb.cdb_tag, r_entry.rs1_valid, r_entry.rs1_tag);
  assign w_hit2    = cdb_hit(i_cdb.cdb_valid, i_cdb.cdb_tag, r_entry.rs2_valid, r_entry.rs2_tag);
  assign w_wr_hit1 = cdb_hit(i_cdb.cdb_valid, i_cdb.cdb_tag, i_wdata.rs1_valid, i_wdata.rs1_tag);
  assign w_wr_hit2 = cdb_hit(i_cdb.cdb_valid, i_cdb.cdb_tag, i_wdata.rs2_valid, i_wdata.rs2_tag);

  // Branch broadcasts wake operands like any other; occupancy comes from the write strobe.
  assign w_unused_ok = ^{i_cdb.cdb_branch, i_wdata.valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry <= '0;
    end else if (i_flush) begin
      r_entry.valid <= 1'b0;
    end else if (i_write) begin
      r_entry       <= i_wdata;
      r_entry.valid <= 1'b1;
      if (w_wr_hit1) begin
        r_entry.rs1_data  <= i_cdb.cdb_result;
        r_entry.rs1_valid <= 1'b1;
      end
      if (w_wr_hit2) begin
        r_entry.rs2_data  <= i_cdb.cdb_result;
        r_entry.rs2_valid <= 1'b1;
      end
    end else if (i_pop) begin
      r_entry.valid <= 1'b0;
    end else if (r_entry.valid) begin
      if (w_hit1) begin
        r_entry.rs1_data  <= i_cdb.cdb_result;
        r_entry.rs1_valid <= 1'b1;
      end
      if (w_hit2) begin
        r_entry.rs2_data  <= i_cdb.cdb_result;
        r_entry.rs2_valid <= 1'b1;
      end
    end
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/div_issue_queue.sv
// rtl/div_issue_queue.sv - in-order circular issue queue feeding the divider
// Head entry issues once both operands are ready and the divider is free.
module div_issue_queue
  import div_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       i_dispatch_en,
  input  div_rs_entry                i_dispatch_data,
  input  cdb_bfm                     i_cdb,
  input  logic                       i_exec_busy,
  input  logic                       issue_granted,
  output logic                       o_issue_req,
  output common_fifo_data            o_issue_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  div_rs_entry w_entries [DEPTH];
  div_rs_entry w_head;
  logic        w_issue_req;
  logic        w_push;
  logic        w_pop;
  logic        w_unused_ok;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // Full is taken from the registered count, so a same-cycle pop never makes room.
  assign w_push = i_dispatch_en && !o_full && !flush;
  assign w_pop  = issue_granted && w_issue_req;

  assign w_head      = w_entries[r_head];
  assign w_issue_req = w_head.valid && w_head.rs1_valid && w_head.rs2_valid
                       && !i_exec_busy && !flush;
  assign w_unused_ok = ^{w_head.rs1_tag, w_head.rs2_tag};

  assign o_issue_req = w_issue_req;
  always_comb begin
    o_issue_data = '0;
    if (w_issue_req) begin
      o_issue_data.rd_tag   = w_head.rd_tag;
      o_issue_data.rs1_data = w_head.rs1_data;
      o_issue_data.rs2_data = w_head.rs2_data;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    div_rs_entry_slot u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (flush),
      .i_write (w_push && (r_tail == PTR_W'(g))),
      .i_wdata (i_dispatch_data),
      .i_pop   (w_pop && (r_head == PTR_W'(g))),
      .i_cdb   (i_cdb),
      .o_entry (w_entries[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_queue.sv
// tb/tb_div_issue_queue.sv - self-checking bench for div_issue_queue
// Vector table for single-entry wakeup cases, hand sequences for queue corners.
module tb_div_issue_queue;
  import div_issue_queue_pkg::*;

  localparam int DEPTH = 4;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       flush;
  logic                       i_dispatch_en;
  div_rs_entry                i_dispatch_data;
  cdb_bfm                     i_cdb;
  logic                       i_exec_busy;
  logic                       issue_granted;
  logic                       o_issue_req;
  common_fifo_data            o_issue_data;
  logic                       o_full;
  logic                       o_empty;
  logic [$clog2(DEPTH+1)-1:0] o_count;

  div_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .i_dispatch_en   (i_dispatch_en),
    .i_dispatch_data (i_dispatch_data),
    .i_cdb           (i_cdb),
    .i_exec_busy     (i_exec_busy),
    .issue_granted   (issue_granted),
    .o_issue_req     (o_issue_req),
    .o_issue_data    (o_issue_data),
    .o_full          (o_full),
    .o_empty         (o_empty),
    .o_count         (o_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  common_fifo_data sb_q[$];

  typedef struct {
    int rd, d1, v1, t1, d2, v2, t2;
    int cs, cn, ctag, cres, cbr;
    int exp_req, e1, e2;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic div_rs_entry mk_entry(input int rd, input int d1, input int v1, input int t1,
                                           input int d2, input int v2, input int t2);
    div_rs_entry e;
    e.valid     = 1'b1;
    e.rd_tag    = TAG_W'(rd);
    e.rs1_data  = XLEN'(d1);
    e.rs1_valid = (v1 != 0);
    e.rs1_tag   = TAG_W'(t1);
    e.rs2_data  = XLEN'(d2);
    e.rs2_valid = (v2 != 0);
    e.rs2_tag   = TAG_W'(t2);
    return e;
  endfunction

  function automatic cdb_bfm mk_cdb(input int tag, input int res, input int br);
    cdb_bfm c;
    c.cdb_valid  = 1'b1;
    c.cdb_tag    = TAG_W'(tag);
    c.cdb_result = XLEN'(res);
    c.cdb_branch = (br != 0);
    return c;
  endfunction

  function automatic void push_exp(input int rd, input int d1, input int d2);
    common_fifo_data f;
    f.rd_tag   = TAG_W'(rd);
    f.rs1_data = XLEN'(d1);
    f.rs2_data = XLEN'(d2);
    sb_q.push_back(f);
  endfunction

  task automatic idle();
    flush           = 1'b0;
    i_dispatch_en   = 1'b0;
    i_dispatch_data = '0;
    i_cdb           = '0;
    i_exec_busy     = 1'b0;
    issue_granted   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input div_rs_entry e);
    i_dispatch_en   = 1'b1;
    i_dispatch_data = e;
    tick();
    i_dispatch_en   = 1'b0;
  endtask

  // Head must be requesting; its payload is checked against the scoreboard, then granted.
  task automatic grant_check(input string name);
    common_fifo_data e;
    #1;
    chk({name, "_req"}, 128'(o_issue_req), 128'(1));
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_sb: got issue with empty scoreboard expected queued entry", name);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_data"}, 128'(o_issue_data), 128'(e));
    end
    issue_granted = 1'b1;
    tick();
    issue_granted = 1'b0;
  endtask

  initial begin
    vecs[0] = '{5, 100, 1, 0, 7, 1, 0, 0, 0, 0, 0, 0, 1, 100, 7};
    vecs[1] = '{2, 11, 1, 0, 'hdead, 0, 9, 0, 1, 9, 4, 0, 0, 11, 4};
    vecs[2] = '{3, 0, 0, 3, 8, 1, 0, 1, 0, 3, 12, 0, 1, 12, 8};
    vecs[3] = '{4, 0, 0, 6, 0, 0, 6, 0, 1, 6, 77, 1, 0, 77, 77};
    vecs[4] = '{6, 30, 1, 4, 0, 0, 4, 0, 1, 4, 99, 0, 0, 30, 99};
    vecs[5] = '{7, 1, 1, 5, 2, 1, 5, 1, 0, 5, 9, 0, 1, 1, 2};

    rst_n = 1'b0;
    idle();
    #1;
    chk("rst_empty", 128'(o_empty), 128'(1));
    chk("rst_full", 128'(o_full), 128'(0));
    chk("rst_count", 128'(o_count), 128'(0));
    chk("rst_req", 128'(o_issue_req), 128'(0));
    chk("rst_data", 128'(o_issue_data), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      i_dispatch_en   = 1'b1;
      i_dispatch_data = mk_entry(vecs[i].rd, vecs[i].d1, vecs[i].v1, vecs[i].t1,
                                 vecs[i].d2, vecs[i].v2, vecs[i].t2);
      if (vecs[i].cs != 0) i_cdb = mk_cdb(vecs[i].ctag, vecs[i].cres, vecs[i].cbr);
      tick();
      i_dispatch_en = 1'b0;
      i_cdb         = '0;
      #1;
      chk($sformatf("v%0d_req_disp", i), 128'(o_issue_req), 128'(vecs[i].exp_req));
      chk($sformatf("v%0d_count", i), 128'(o_count), 128'(1));
      if (vecs[i].cn != 0) begin
        i_cdb = mk_cdb(vecs[i].ctag, vecs[i].cres, vecs[i].cbr);
        #1;
        chk($sformatf("v%0d_req_cdb_cycle", i), 128'(o_issue_req), 128'(0));
        tick();
        i_cdb = '0;
      end
      push_exp(vecs[i].rd, vecs[i].e1, vecs[i].e2);
      grant_check($sformatf("v%0d_issue", i));
      chk($sformatf("v%0d_empty", i), 128'(o_empty), 128'(1));
    end

    // Busy divider masks the request; a grant without request changes nothing.
    dispatch(mk_entry(1, 10, 1, 0, 20, 1, 0));
    i_exec_busy   = 1'b1;
    #1;
    chk("busy_req", 128'(o_issue_req), 128'(0));
    chk("busy_data", 128'(o_issue_data), 128'(0));
    issue_granted = 1'b1;
    tick();
    issue_granted = 1'b0;
    chk("busy_grant_count", 128'(o_count), 128'(1));
    i_exec_busy   = 1'b0;
    #1;
    chk("busy_drop_req", 128'(o_issue_req), 128'(1));
    push_exp(1, 10, 20);
    grant_check("busy_issue");

    // Fill, drop a dispatch while full alongside a pop, then wrap the pointers.
    for (int i = 0; i < 4; i++) begin
      dispatch(mk_entry(10 + i, 100 + i, 1, 0, 200 + i, 1, 0));
      push_exp(10 + i, 100 + i, 200 + i);
    end
    chk("fill_full", 128'(o_full), 128'(1));
    chk("fill_count", 128'(o_count), 128'(4));
    i_dispatch_en   = 1'b1;
    i_dispatch_data = mk_entry(14, 114, 1, 0, 214, 1, 0);
    grant_check("full_pop");
    i_dispatch_en   = 1'b0;
    chk("full_drop_count", 128'(o_count), 128'(3));
    chk("full_drop_full", 128'(o_full), 128'(0));
    dispatch(mk_entry(15, 115, 1, 0, 215, 1, 0));
    push_exp(15, 115, 215);
    chk("wrap_count", 128'(o_count), 128'(4));
    grant_check("drain0");
    grant_check("drain1");
    i_dispatch_en   = 1'b1;
    i_dispatch_data = mk_entry(16, 116, 1, 0, 216, 1, 0);
    push_exp(16, 116, 216);
    grant_check("push_pop");
    i_dispatch_en   = 1'b0;
    chk("push_pop_count", 128'(o_count), 128'(2));
    grant_check("drain2");
    grant_check("drain3");
    chk("drain_empty", 128'(o_empty), 128'(1));

    // Wakeup of the second entry in the cycle the head is popped.
    dispatch(mk_entry(20, 5, 1, 0, 6, 1, 0));
    push_exp(20, 5, 6);
    dispatch(mk_entry(21, 0, 0, 8, 3, 1, 0));
    push_exp(21, 55, 3);
    i_cdb = mk_cdb(8, 55, 0);
    grant_check("pop_cdb_head");
    i_cdb = '0;
    grant_check("pop_cdb_next");

    // Flush with concurrent dispatch and grant.
    for (int i = 0; i < 3; i++) dispatch(mk_entry(30 + i, i, 1, 0, i, 1, 0));
    flush           = 1'b1;
    i_dispatch_en   = 1'b1;
    i_dispatch_data = mk_entry(33, 1, 1, 0, 1, 1, 0);
    issue_granted   = 1'b1;
    #1;
    chk("flush_req_mask", 128'(o_issue_req), 128'(0));
    tick();
    idle();
    #1;
    chk("flush_count", 128'(o_count), 128'(0));
    chk("flush_empty", 128'(o_empty), 128'(1));
    chk("flush_req_next", 128'(o_issue_req), 128'(0));

    // Asynchronous reset mid-operation.
    dispatch(mk_entry(40, 1, 1, 0, 2, 1, 0));
    dispatch(mk_entry(41, 3, 1, 0, 4, 1, 0));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 128'(o_count), 128'(0));
    chk("arst_req", 128'(o_issue_req), 128'(0));
    #1 rst_n = 1'b1;
    tick();
    chk("arst_post_req", 128'(o_issue_req), 128'(0));
    chk("arst_post_empty", 128'(o_empty), 128'(1));

    chk("sb_drained", 128'(sb_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
